// File: rtl/seq_mult_if.sv
// Operand/result bundle between the execute stage (master) and seq_mult (slave).
interface seq_mult_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier, one WIDTH-bit add per cycle, WIDTH iterations per product.
// Define MULT_SIGNED_EN for two's-complement operands (adds a NEG state, latency WIDTH+1).
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  if (WIDTH % 4 != 0) begin : g_bad_width
    $error("seq_mult: WIDTH must be a multiple of 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef MULT_SIGNED_EN
    , NEG = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef MULT_SIGNED_EN
  logic                 sign_q, sign_d;
`endif

  logic [WIDTH:0]       hi_ext;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;
  logic                 last_iter;

  // One adder pass: carry slot + high half, plus mcand when the current multiplier bit is set.
  always_comb begin
    hi_ext    = {acc_q[2*WIDTH], acc_q[2*WIDTH-1:WIDTH]};
    addend    = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum       = hi_ext + addend;
    shifted   = {1'b0, sum, acc_q[WIDTH-1:1]};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values, independent of process ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (last_iter) begin
`ifdef MULT_SIGNED_EN
          state_d = NEG;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG:  state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      RUN:  bus.busy = 1'b1;
`ifdef MULT_SIGNED_EN
      NEG:  bus.busy = 1'b1;
`endif
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.product = product_q;

  // Datapath next-state: load, iterate, and (signed) final negate.
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    sign_d    = sign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef MULT_SIGNED_EN
          // 0x8000 negates to itself and is then read as unsigned magnitude 0x8000.
          mcand_d = bus.a[WIDTH-1] ? -bus.a : bus.a;
          acc_d   = {1'b0, {WIDTH{1'b0}}, (bus.b[WIDTH-1] ? -bus.b : bus.b)};
          sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
          mcand_d = bus.a;
          acc_d   = {1'b0, {WIDTH{1'b0}}, bus.b};
`endif
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = shifted;
        cnt_d = cnt_q + 1'b1;
`ifndef MULT_SIGNED_EN
        if (last_iter) product_d = shifted[2*WIDTH-1:0];
`endif
      end
`ifdef MULT_SIGNED_EN
      NEG: product_d = sign_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=16); expectations follow MULT_SIGNED_EN when it is defined.
module tb_seq_mult;

`ifdef MULT_SIGNED_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_mult_if #(.WIDTH(16)) bus ();

  seq_mult #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one request (sampled at the next rising edge, E0) and waits for done.
  // lat is the index k of the edge Ek after which done is seen; busy_cycles counts busy=1 samples before done.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        output logic [31:0] res, output int lat,
                        output int busy_cycles, output bit seen);
    bus.start = 1'b1;
    bus.a     = op_a;
    bus.b     = op_b;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.a       = 16'($urandom);
    bus.b       = 16'($urandom);
    res         = '0;
    lat         = -1;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        res  = bus.product;
      end else if (bus.busy) begin
        busy_cycles++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.product !== 32'h0) begin n_bad++; $display("FAIL reset_product: got %h want %h", bus.product, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res; int lat, bc; bit seen;
    run_op(16'h1234, 16'h0010, res, lat, bc, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL basic_done_seen: got none want one within 40 cycles"); end
    n_cmp++; if (res !== 32'h0001_2340) begin n_bad++; $display("FAIL basic_product: got %h want %h", res, 32'h0001_2340); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency: got E%0d want E%0d", lat, LAT); end
    n_cmp++; if (bc !== LAT) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, LAT); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_done: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse_width: got %b want 0", bus.done); end
  endtask

  task automatic test_carry();
    logic [31:0] res, exp; int lat, bc; bit seen;
`ifdef MULT_SIGNED_EN
    exp = 32'h0000_0001;
`else
    exp = 32'hFFFE_0001;
`endif
    run_op(16'hFFFF, 16'hFFFF, res, lat, bc, seen);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL carry_product: got %h want %h", res, exp); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL carry_latency: got E%0d want E%0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    logic [31:0] prev; int first_done, n_done; bit hold_bad;
    prev = bus.product;
    bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    first_done = -1; n_done = 0; hold_bad = 1'b0;
    for (int i = 4; i < 44; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end else if (first_done < 0 && bus.product !== prev) begin
        hold_bad = 1'b1;
      end
    end
    n_cmp++; if (bus.product !== 32'h0000_000F) begin n_bad++; $display("FAIL ignore_product: got %h want %h", bus.product, 32'h0000_000F); end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
    n_cmp++; if (first_done !== LAT) begin n_bad++; $display("FAIL ignore_latency: got E%0d want E%0d", first_done, LAT); end
    n_cmp++; if (hold_bad !== 1'b0) begin n_bad++; $display("FAIL ignore_product_hold: got changed want held %h", prev); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat, bc; bit seen;
    run_op(16'd2, 16'd3, res, lat, bc, seen);
    n_cmp++; if (res !== 32'd6) begin n_bad++; $display("FAIL b2b_first_product: got %h want %h", res, 32'd6); end
    bus.start = 1'b1; bus.a = 16'd5; bus.b = 16'd5;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_done_ignored: busy got %b want 0", bus.busy); end
    run_op(16'd9, 16'd4, res, lat, bc, seen);
    n_cmp++; if (res !== 32'd36) begin n_bad++; $display("FAIL b2b_second_product: got %h want %h", res, 32'd36); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_second_latency: got E%0d want E%0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [31:0] res; int lat, bc; bit seen;
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.product !== 32'h0) begin n_bad++; $display("FAIL midrst_product: got %h want %h", bus.product, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd3, 16'd4, res, lat, bc, seen);
    n_cmp++; if (res !== 32'd12) begin n_bad++; $display("FAIL midrst_after_product: got %h want %h", res, 32'd12); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL midrst_after_latency: got E%0d want E%0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_sign_cases();
    logic [31:0] res, exp1, exp2; int lat, bc; bit seen;
`ifdef MULT_SIGNED_EN
    exp1 = 32'hFFFF_FFFD;
    exp2 = 32'h0000_8000;
`else
    exp1 = 32'h0002_FFFD;
    exp2 = 32'h7FFF_8000;
`endif
    run_op(16'hFFFF, 16'h0003, res, lat, bc, seen);
    n_cmp++; if (res !== exp1) begin n_bad++; $display("FAIL sign_neg1x3_product: got %h want %h", res, exp1); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL sign_neg1x3_latency: got E%0d want E%0d", lat, LAT); end
    @(negedge clk);
    run_op(16'h8000, 16'hFFFF, res, lat, bc, seen);
    n_cmp++; if (res !== exp2) begin n_bad++; $display("FAIL sign_min_product: got %h want %h", res, exp2); end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    test_basic();
    test_carry();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midop();
    test_sign_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
